tuner_pitch_detector: RTL

- Receive side of the tuner's audio path: consumes signed 24-bit samples from the codec ADC at 48 kHz and measures pitch by counting samples between hysteresis-qualified rising zero crossings.
- Accumulates 8 consecutive periods, then compares the result against the target period of the string chosen by `select`.
- Drives flat/sharp/in-tune indicators.
- Input format and `select` encoding match the tone generator: 0=E330, 1=A440, 2=D587, 3=G784, 4=B985, 5=E1319.

---
 rtl/tuner_pitch_detector.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/tuner_pitch_detector.sv
// ---------------------------------------------------------------------------
// tuner_pitch_detector
//
// Measures the pitch of the incoming audio. It counts samples between rising
// zero crossings that pass a hysteresis check. The count is summed over 8
// consecutive periods. The sum is then compared against the target for the
// selected string, and the flat, sharp and in-tune indicators are driven from
// that comparison.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-low reset
//   audio_in     signed 24-bit sample
//   audio_valid  one-cycle strobe; audio_in is valid while high
//   select       target string: 0=E330 1=A440 2=D587 3=G784 4=B985 5=E1319
//   period_sum   sample count spanning the last 8 periods
//   meas_valid   one-cycle pulse when period_sum / indicators update
//   flat         period_sum > target + TOL
//   sharp        period_sum < target - TOL
//   in_tune      |period_sum - target| <= TOL
//   no_signal    high while no valid measurement is held
//   dbg_state    FSM state (0 = SEEK, 1 = MEASURE)
//
// Handshake: audio_in is consumed on every clk edge where audio_valid=1.
// There is no back-pressure. Every piece of state except meas_valid holds
// while audio_valid=0.
// ---------------------------------------------------------------------------
module tuner_pitch_detector #(
   parameter logic signed [23:0] HYST    = 24'sd4096,
   parameter int                 TOL     = 4,
   parameter int                 TIMEOUT = 4095
) (
   input  logic               clk,
   input  logic               reset,
   input  logic signed [23:0] audio_in,
   input  logic               audio_valid,
   input  logic [2:0]         select,
   output logic [15:0]        period_sum,
   output logic               meas_valid,
   output logic               flat,
   output logic               sharp,
   output logic               in_tune,
   output logic               no_signal,
   output logic               dbg_state
);

   localparam logic [15:0]        TIMEOUT_C = TIMEOUT[15:0];
   localparam logic signed [16:0] TOL_C     = TOL[16:0];

   typedef enum logic {SEEK = 1'b0, MEASURE = 1'b1} state_t;

   state_t             state, state_next;
   logic               arm;
   logic [15:0]        cnt;
   logic [2:0]         xings;
   logic               crossing;
   logic               close_win;
   logic               time_out;
   logic [15:0]        cnt_inc;
   logic [15:0]        target;
   logic               sel_ok;
   logic signed [16:0] diff;

   // A crossing is a sample at or above +HYST that follows a sample at or
   // below -HYST. Samples between the two thresholds leave arm unchanged.
   assign crossing = arm && (audio_in >= HYST);
   assign cnt_inc  = cnt + 16'd1;

   // Target LUT (8-period sums). Select codes 6 and 7 have no string.
   always_comb begin
      target = 16'd0;
      sel_ok = 1'b1;
      case (select)
         3'd0:    target = 16'd1164;
         3'd1:    target = 16'd873;
         3'd2:    target = 16'd654;
         3'd3:    target = 16'd490;
         3'd4:    target = 16'd390;
         3'd5:    target = 16'd291;
         default: sel_ok = 1'b0;
      endcase
   end

   // 17-bit signed difference: both operands are zero-extended, so it cannot wrap.
   assign diff = $signed({1'b0, cnt_inc}) - $signed({1'b0, target});

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= SEEK;
      else        state <= state_next;
   end

   // Next-state logic. A window that closes on the same sample as the
   // timeout takes priority over the timeout.
   always_comb begin
      state_next = state;
      close_win  = 1'b0;
      time_out   = 1'b0;
      if (audio_valid) begin
         case (state)
            SEEK: begin
               if (crossing) state_next = MEASURE;
            end
            MEASURE: begin
               if (crossing && xings == 3'd7) begin
                  close_win = 1'b1;
               end else if (cnt == TIMEOUT_C) begin
                  time_out   = 1'b1;
                  state_next = SEEK;
               end
            end
            default: state_next = SEEK;
         endcase
      end
   end

   // Output decode
   always_comb begin
      dbg_state = (state == MEASURE);
   end

   // Datapath and registered indicators
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         arm        <= 1'b0;
         cnt        <= 16'd0;
         xings      <= 3'd0;
         period_sum <= 16'd0;
         meas_valid <= 1'b0;
         flat       <= 1'b0;
         sharp      <= 1'b0;
         in_tune    <= 1'b0;
         no_signal  <= 1'b1;
      end else begin
         meas_valid <= 1'b0;
         if (audio_valid) begin
            if (audio_in <= -HYST) arm <= 1'b1;
            else if (crossing)     arm <= 1'b0;

            if (state == SEEK) begin
               if (crossing) begin
                  cnt   <= 16'd0;
                  xings <= 3'd0;
               end
            end else if (close_win) begin
               // The closing crossing is the last sample of this window and
               // also the opening crossing of the next one.
               period_sum <= cnt_inc;
               meas_valid <= 1'b1;
               cnt        <= 16'd0;
               xings      <= 3'd0;
               no_signal  <= 1'b0;
               flat       <= sel_ok && (diff > TOL_C);
               sharp      <= sel_ok && (diff < -TOL_C);
               in_tune    <= sel_ok && (diff <= TOL_C) && (diff >= -TOL_C);
            end else if (time_out) begin
               no_signal <= 1'b1;
               flat      <= 1'b0;
               sharp     <= 1'b0;
               in_tune   <= 1'b0;
            end else begin
               cnt <= cnt_inc;
               if (crossing) xings <= xings + 3'd1;
            end
         end
      end
   end

endmodule
